ml_ahb_wrr_arb: RTL and testbench
=================================

# ml_ahb_wrr_arb

Weighted round-robin slave-port arbiter for the multilayer AHB matrix. It shares one slave port between `NB_MASTER_PORT` masters and gives each master a programmable number of consecutive transactions per turn. It never breaks a SEQ burst or a locked sequence. It sits between the per-master request decode and the slave-port address/data mux, and drives a registered one-hot grant.

## Interface
- `NB_MASTER_PORT`, 4: number of masters sharing the port (2..16).
- `IDX_WIDTH`, 2: ceil(log2(`NB_MASTER_PORT`)), minimum 1.
- `WEIGHT_WIDTH`, 4: width of each per-master weight.

- `hclk`  in  1  port clock; everything is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mx_sel`  in  `NB_MASTER_PORT`  master i addresses this port this cycle.
- `mx_htrans0`  in  `NB_MASTER_PORT`  htrans[0] of master i: 1 = SEQ, 0 = NONSEQ/IDLE.
- `mx_hlock`  in  `NB_MASTER_PORT`  hlock of master i.
- `hready`  in  1  slave-port hready; 0 stalls the transfer in progress.
- `weight`  in  `NB_MASTER_PORT*WEIGHT_WIDTH`  consecutive transactions allowed per turn; field i sits at [i*W +: W]; value 0 is treated as 1.
- `mx_arb_grant`  out  `NB_MASTER_PORT`  registered one-hot grant, or all zero.
- `grant_valid`  out  1  registered; equals |`mx_arb_grant`.
- `grant_idx`  out  `IDX_WIDTH`  registered index of the owner; holds its last value when `grant_valid`=0.
- `arb_switch`  out  1  registered one-cycle pulse when the owner changes, including IDLE→owner.

## Operation
- States: `IDLE` (no owner) and `OWNED` (owner = `grant_idx`). Internal registers:
  - `cnt` (`WEIGHT_WIDTH`): remaining quota.
  - `last_idx`: most recent owner; reset value `NB_MASTER_PORT-1`.
  - `deny_d`: sticky pending bits.
- A request is `nseq_i = mx_sel[i] & ~mx_htrans0[i]`. Pending is `pend = mx_sel | deny_d`.
- A hold condition applies when state is `OWNED` and the owner has `mx_sel & (mx_htrans0 | mx_hlock)`, i.e. it is mid-burst or locked.
- An arbitration point is `hready=1 & ~hold`. When `hready=0`, every register is frozen.
- Round-robin pick: the first set bit of `pend`, searching from `(last_idx+1) mod N` upward with wrap. The owner's own bit is excluded when it is being displaced.
- At an arbitration point:
  - **Owner still requesting, and (`cnt`≠0 or no other bit of `pend` set):** keep the owner. `cnt` ← `cnt`−1, saturating at 0.
  - **Owner requesting, `cnt`=0, others pending:** grant the RR pick among the others. `cnt` ← weff−1.
  - **State `IDLE`, or owner not selecting, with `pend`≠0:** grant the RR pick. `cnt` ← weff−1.
  - **`pend`=0:** go to `IDLE` and clear the grant.
- weff = max(`weight[new]`, 1). `weight` is sampled only when the counter is loaded.
- On a new grant, `last_idx` ← new owner.
- `deny_d[i]`, when `hready=1`:
  - cleared when i is granted for the next cycle;
  - set when `nseq_i`=1 and i is not granted for the next cycle.
- Counter arithmetic is unsigned. Decrement saturates at 0. There is no wrap.

## Timing
- Grant latency: a request sampled with `hready=1` at edge k produces the grant at edge k+1.
- `mx_arb_grant`, `grant_idx`, `grant_valid`, `arb_switch` and `cnt` change only on edges where `hready=1`, or on `reset`.
- `arb_switch` is high for exactly the one cycle after an owner change. It stays 0 on a keep decision and on a transition to `IDLE`.
- Reset values: all outputs 0, `deny_d`=0, `cnt`=0, `last_idx`=N−1, state `IDLE`.
- Reset asserted mid-burst takes effect at the next edge, regardless of `hready` or hold.
- Simultaneous requests are resolved by RR order only; there is no fixed priority.

## Structure
- Package `ml_ahb_arb_pkg` holds:
  - state enum `ARB_IDLE`/`ARB_OWNED`;
  - the `F_WEIGHT_FIELD` slicing function;
  - the weff helper.
- Sub-module `ml_ahb_rr_pick`: combinational. Inputs are a request vector and a start index. Outputs are a one-hot pick, its index and a found flag.
- The top module holds the FSM, `cnt`, `last_idx`, `deny_d` and the output registers.

## Test plan
- **Reset:** assert `reset` 2 cycles → `mx_arb_grant`=4'b0000, `grant_valid`=0, `grant_idx`=0, `arb_switch`=0.
- **Single requester:** `mx_sel`=4'b0100, NONSEQ, `hready`=1 → next cycle `mx_arb_grant`=4'b0100, `grant_idx`=2, `arb_switch`=1 for one cycle.
- **Weighting:** masters 0 and 1 issue NONSEQ every cycle, weight0=2, weight1=1 → grant sequence over successive arbitration points is 0,0,1,0,0,1.
- **Burst hold:** master 0 owns with `cnt`=0 and issues 3 SEQ beats while master 1 requests NONSEQ → grant stays 4'b0001 for the 3 beats and `deny_d[1]`=1. Master 1 is granted the cycle after master 0's next non-SEQ arbitration point.
- **Stall:** `hready`=0 for 4 cycles while a new request arrives → grant, `cnt` and `deny_d` unchanged. Arbitration resolves one edge after `hready` returns to 1.
- **Reset mid-operation:** `reset` during a locked burst of master 3 → grant cleared next edge. After release, simultaneous requests from masters 0 and 3 grant master 0 first.

Source files
------------

// File: rtl/ml_ahb_arb_pkg.sv
// Shared types, state encodings and weight helpers for the weighted round-robin
// slave-port arbiter of the multilayer AHB matrix.
package ml_ahb_arb_pkg;

  // Upper bounds used to size the helper functions independently of the instance.
  localparam int unsigned MAX_MASTERS      = 16;
  localparam int unsigned MAX_WEIGHT_WIDTH = 16;

  typedef logic [MAX_MASTERS*MAX_WEIGHT_WIDTH-1:0] weight_vec_t;
  typedef logic [MAX_WEIGHT_WIDTH-1:0]             weight_t;

  // Arbiter states, kept as plain constants for legacy tool flows.
  localparam logic [0:0] ARB_IDLE  = 1'b0;
  localparam logic [0:0] ARB_OWNED = 1'b1;

  // Extract field idx of a packed weight vector whose fields are width bits wide.
  function automatic weight_t F_WEIGHT_FIELD(input weight_vec_t weights,
                                             input int unsigned idx,
                                             input int unsigned width);
    weight_vec_t shifted;
    shifted = weights >> (idx * width);
    return shifted[MAX_WEIGHT_WIDTH-1:0] & weight_t'((32'd1 << width) - 32'd1);
  endfunction

  // Effective weight: a programmed zero still grants one transaction per turn.
  function automatic weight_t F_WEFF(input weight_t w);
    return (w == '0) ? weight_t'(1) : w;
  endfunction

endpackage

// File: rtl/ml_ahb_wrr_arb_if.sv
// Request/grant bundle between the per-master decode and the slave-port arbiter.
interface ml_ahb_wrr_arb_if #(
  parameter int unsigned NB_MASTER_PORT = 4,
  parameter int unsigned IDX_WIDTH      = 2,
  parameter int unsigned WEIGHT_WIDTH   = 4
);

  logic [NB_MASTER_PORT-1:0]              mx_sel;
  logic [NB_MASTER_PORT-1:0]              mx_htrans0;
  logic [NB_MASTER_PORT-1:0]              mx_hlock;
  logic                                   hready;
  logic [NB_MASTER_PORT*WEIGHT_WIDTH-1:0] weight;
  logic [NB_MASTER_PORT-1:0]              mx_arb_grant;
  logic                                   grant_valid;
  logic [IDX_WIDTH-1:0]                   grant_idx;
  logic                                   arb_switch;

  // Request side: the decode logic driving the arbiter.
  modport master (
    output mx_sel, mx_htrans0, mx_hlock, hready, weight,
    input  mx_arb_grant, grant_valid, grant_idx, arb_switch
  );

  // Arbiter side.
  modport slave (
    input  mx_sel, mx_htrans0, mx_hlock, hready, weight,
    output mx_arb_grant, grant_valid, grant_idx, arb_switch
  );

endinterface

// File: rtl/ml_ahb_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after start, with wrap.
module ml_ahb_rr_pick #(
  parameter int unsigned NB_MASTER_PORT = 4,
  parameter int unsigned IDX_WIDTH      = 2
) (
  input  logic [NB_MASTER_PORT-1:0] req,
  input  logic [IDX_WIDTH-1:0]      start,
  output logic [NB_MASTER_PORT-1:0] pick,
  output logic [IDX_WIDTH-1:0]      pick_idx,
  output logic                      found
);

  int unsigned         pos;
  logic [IDX_WIDTH-1:0] pos_idx;

  // Scan every offset from start; the first hit wins.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    pos      = 0;
    pos_idx  = '0;
    for (int unsigned i = 0; i < NB_MASTER_PORT; i++) begin
      pos     = (32'(start) + i) % NB_MASTER_PORT;
      pos_idx = IDX_WIDTH'(pos);
      if (!found && req[pos_idx]) begin
        found          = 1'b1;
        pick[pos_idx]  = 1'b1;
        pick_idx       = pos_idx;
      end
    end
  end

endmodule

// File: rtl/ml_ahb_wrr_arb.sv
// Weighted round-robin arbiter sharing one AHB slave port between several masters.
// Bursts (SEQ) and locked sequences of the owner are never interrupted.
module ml_ahb_wrr_arb
  import ml_ahb_arb_pkg::*;
#(
  parameter int unsigned NB_MASTER_PORT = 4,
  parameter int unsigned IDX_WIDTH      = 2,
  parameter int unsigned WEIGHT_WIDTH   = 4
) (
  input logic             hclk,
  input logic             reset,
  ml_ahb_wrr_arb_if.slave bus
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX_RST = IDX_WIDTH'(NB_MASTER_PORT - 1);

  logic [0:0]                state_q, state_d;
  logic [NB_MASTER_PORT-1:0] grant_q, grant_d;
  logic [IDX_WIDTH-1:0]      grant_idx_q, grant_idx_d;
  logic                      grant_valid_q;
  logic                      switch_q, switch_d;
  logic [WEIGHT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [IDX_WIDTH-1:0]      last_idx_q, last_idx_d;
  logic [NB_MASTER_PORT-1:0] deny_q, deny_d;

  logic [NB_MASTER_PORT-1:0] nseq, pend, own_oh, others, pick_req, pick_oh;
  logic [IDX_WIDTH-1:0]      pick_idx, start_idx;
  logic                      pick_found, owner_sel, hold, keep;
  weight_t                   w_field, w_eff;
  logic [WEIGHT_WIDTH-1:0]   cnt_load;

  // Request decode, hold detection and the candidate set for the picker.
  always_comb begin
    nseq      = bus.mx_sel & ~bus.mx_htrans0;
    pend      = bus.mx_sel | deny_q;
    own_oh    = '0;
    own_oh[grant_idx_q] = 1'b1;
    others    = pend & ~own_oh;
    owner_sel = (state_q == ARB_OWNED) && bus.mx_sel[grant_idx_q];
    hold      = owner_sel && (bus.mx_htrans0[grant_idx_q] || bus.mx_hlock[grant_idx_q]);
    keep      = owner_sel && ((cnt_q != '0) || (others == '0));
    // A requesting owner competes only when displaced, so its bit is masked out.
    pick_req  = owner_sel ? others : pend;
    start_idx = (last_idx_q == LAST_IDX_RST) ? '0 : last_idx_q + 1'b1;
  end

  ml_ahb_rr_pick #(
    .NB_MASTER_PORT (NB_MASTER_PORT),
    .IDX_WIDTH      (IDX_WIDTH)
  ) u_rr_pick (
    .req      (pick_req),
    .start    (start_idx),
    .pick     (pick_oh),
    .pick_idx (pick_idx),
    .found    (pick_found)
  );

  // Quota reload value for the newly picked master.
  always_comb begin
    w_field  = F_WEIGHT_FIELD(weight_vec_t'(bus.weight), 32'(pick_idx), WEIGHT_WIDTH);
    w_eff    = F_WEFF(w_field);
    cnt_load = WEIGHT_WIDTH'(w_eff - 1'b1);
  end

  // Arbitration decision: keep, displace, grant from idle, or release.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    last_idx_d  = last_idx_q;
    cnt_d       = cnt_q;
    switch_d    = 1'b0;
    if (!hold) begin
      if (keep) begin
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
      end else if (pick_found) begin
        state_d     = ARB_OWNED;
        grant_d     = pick_oh;
        grant_idx_d = pick_idx;
        last_idx_d  = pick_idx;
        cnt_d       = cnt_load;
        switch_d    = !((state_q == ARB_OWNED) && (pick_idx == grant_idx_q));
      end else begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    end
    // Remember NONSEQ requests that lost, until they are served.
    deny_d = (deny_q | nseq) & ~grant_d;
  end

  // State and output registers; everything freezes while the slave stalls.
  always_ff @(posedge hclk) begin
    if (reset) begin
      state_q       <= ARB_IDLE;
      grant_q       <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      switch_q      <= 1'b0;
      cnt_q         <= '0;
      last_idx_q    <= LAST_IDX_RST;
      deny_q        <= '0;
    end else if (bus.hready) begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= |grant_d;
      switch_q      <= switch_d;
      cnt_q         <= cnt_d;
      last_idx_q    <= last_idx_d;
      deny_q        <= deny_d;
    end
  end

  assign bus.mx_arb_grant = grant_q;
  assign bus.grant_valid  = grant_valid_q;
  assign bus.grant_idx    = grant_idx_q;
  assign bus.arb_switch   = switch_q;

endmodule

// File: tb/tb_ml_ahb_wrr_arb.sv
// Directed self-checking bench for the weighted round-robin slave-port arbiter.
module tb_ml_ahb_wrr_arb;

  logic hclk;
  logic reset;
  int   n_asserts;
  int   n_fail;

  ml_ahb_wrr_arb_if #(
    .NB_MASTER_PORT (4),
    .IDX_WIDTH      (2),
    .WEIGHT_WIDTH   (4)
  ) bus ();

  ml_ahb_wrr_arb #(
    .NB_MASTER_PORT (4),
    .IDX_WIDTH      (2),
    .WEIGHT_WIDTH   (4)
  ) dut (
    .hclk  (hclk),
    .reset (reset),
    .bus   (bus)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Advance one edge and sample 1 time unit after it.
  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] g, input logic [31:0] idx,
                         input logic [31:0] sw);
    chk({tag, ".grant"}, 32'(bus.mx_arb_grant), g);
    chk({tag, ".valid"}, 32'(bus.grant_valid), (g != 0) ? 1 : 0);
    chk({tag, ".idx"},   32'(bus.grant_idx), idx);
    chk({tag, ".switch"}, 32'(bus.arb_switch), sw);
  endtask

  logic [3:0] exp_g  [6];
  logic [1:0] exp_i  [6];
  logic       exp_sw [6];

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    exp_g  = '{4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0001, 4'b0010};
    exp_i  = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1};
    exp_sw = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    reset          = 1'b1;
    bus.mx_sel     = '0;
    bus.mx_htrans0 = '0;
    bus.mx_hlock   = '0;
    bus.hready     = 1'b1;
    bus.weight     = 16'h1111;

    // Reset held for two edges.
    cyc();
    cyc();
    chk_out("reset", 'b0000, 0, 0);
    chk("reset.cnt", 32'(dut.cnt_q), 0);
    chk("reset.deny", 32'(dut.deny_q), 0);
    chk("reset.last_idx", 32'(dut.last_idx_q), 3);

    // Single requester, master 2.
    reset      = 1'b0;
    bus.mx_sel = 4'b0100;
    cyc();
    chk_out("single", 'b0100, 2, 1);
    bus.mx_sel = 4'b0000;
    cyc();
    chk_out("single_release", 'b0000, 2, 0);

    // Weighting: weight0=2, weight1=1, both request NONSEQ every cycle.
    bus.weight = 16'h1112;
    bus.mx_sel = 4'b0011;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk_out($sformatf("wrr%0d", k), 32'(exp_g[k]), 32'(exp_i[k]), 32'(exp_sw[k]));
      if (k == 0) chk("wrr0.cnt", 32'(dut.cnt_q), 1);
    end
    // Master 0 lost its last NONSEQ, so the sticky bit still wins it a turn.
    bus.mx_sel = 4'b0000;
    cyc();
    chk_out("sticky", 'b0001, 0, 1);
    chk("sticky.deny", 32'(dut.deny_q), 0);
    cyc();
    chk_out("idle", 'b0000, 0, 0);

    // Burst hold; weight0=0 behaves as 1, leaving cnt at 0.
    bus.weight = 16'h1110;
    bus.mx_sel = 4'b0001;
    cyc();
    chk_out("burst_grant", 'b0001, 0, 1);
    chk("burst_grant.cnt", 32'(dut.cnt_q), 0);
    bus.mx_sel     = 4'b0011;
    bus.mx_htrans0 = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk_out($sformatf("burst_beat%0d", k), 'b0001, 0, 0);
      chk($sformatf("burst_beat%0d.deny", k), 32'(dut.deny_q), 'b0010);
    end
    bus.mx_htrans0 = 4'b0000;
    cyc();
    chk_out("burst_handover", 'b0010, 1, 1);
    chk("burst_handover.deny", 32'(dut.deny_q), 'b0001);
    bus.mx_sel = 4'b0000;
    cyc();
    chk_out("burst_back", 'b0001, 0, 1);
    chk("burst_back.deny", 32'(dut.deny_q), 0);
    cyc();
    chk_out("burst_idle", 'b0000, 0, 0);

    // Stall: master 2 owns, master 3 arrives while hready is low.
    bus.mx_sel = 4'b0100;
    cyc();
    chk_out("stall_own", 'b0100, 2, 1);
    cyc();
    chk_out("stall_keep", 'b0100, 2, 0);
    bus.hready = 1'b0;
    bus.mx_sel = 4'b1100;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk_out($sformatf("stall%0d", k), 'b0100, 2, 0);
      chk($sformatf("stall%0d.cnt", k), 32'(dut.cnt_q), 0);
      chk($sformatf("stall%0d.deny", k), 32'(dut.deny_q), 0);
    end
    bus.hready = 1'b1;
    cyc();
    chk_out("stall_resolve", 'b1000, 3, 1);

    // Reset during a locked burst of master 3, with hready low.
    bus.mx_sel     = 4'b1000;
    bus.mx_htrans0 = 4'b1000;
    bus.mx_hlock   = 4'b1000;
    cyc();
    chk_out("locked", 'b1000, 3, 0);
    reset      = 1'b1;
    bus.hready = 1'b0;
    cyc();
    chk_out("mid_reset", 'b0000, 0, 0);
    chk("mid_reset.last_idx", 32'(dut.last_idx_q), 3);
    reset          = 1'b0;
    bus.hready     = 1'b1;
    bus.mx_sel     = 4'b1001;
    bus.mx_htrans0 = 4'b0000;
    bus.mx_hlock   = 4'b0000;
    cyc();
    chk_out("post_reset", 'b0001, 0, 1);
    cyc();
    chk_out("post_reset_rr", 'b1000, 3, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
